cla_nibble_serial_adder: RTL and testbench



---
 rtl/cla_nibble_serial_adder.sv | 149 ++++++++++++++
 tb/tb_cla_nibble_serial_adder.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_nibble_serial_adder.sv
// cla_nibble_serial_adder: WIDTH-bit adder that walks through the operands one
// 4-bit slice per clock, LSB nibble first, using a single 4-bit carry-look-ahead
// slice. The slice carry-out is registered and becomes the next slice's carry-in.
// Optional macro CLA_SERIAL_SUB_EN adds a 'sub' input that turns the block into
// an A-B subtractor (B captured inverted, carry register preset to 1).
module cla_nibble_serial_adder #(
  parameter  int WIDTH   = 16,
  localparam int NIBBLES = WIDTH / 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CLA_SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_reg, b_reg, sum_reg;
  logic             carry, cout_reg, ovf_reg;
  logic [CW-1:0]    cnt;
  logic             last;

  logic [3:0] a_nib, b_nib, g, p, s4;
  logic [4:0] c;

  logic [WIDTH-1:0] b_load;
  logic             carry_load;

`ifdef CLA_SERIAL_SUB_EN
  assign b_load     = sub ? ~b : b;
  assign carry_load = sub ? 1'b1 : cin;
`else
  assign b_load     = b;
  assign carry_load = cin;
`endif

  assign last = (cnt == CW'(NIBBLES - 1));

  // Select the operand nibbles addressed by the slice counter
  always_comb begin
    a_nib = 4'h0;
    b_nib = 4'h0;
    for (int k = 0; k < NIBBLES; k++) begin
      if (cnt == CW'(k)) begin
        a_nib = a_reg[4*k +: 4];
        b_nib = b_reg[4*k +: 4];
      end
    end
  end

  // 4-bit carry-look-ahead slice: all internal carries from generate/propagate
  always_comb begin
    g    = a_nib & b_nib;
    p    = a_nib ^ b_nib;
    c[0] = carry;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);
    s4   = p ^ c[3:0];
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: accept in IDLE, step slices in RUN, hold result in DONE
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (in_valid) state_next = RUN;
      RUN:  if (last) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture operands, then write one sum nibble per RUN cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg    <= '0;
      b_reg    <= '0;
      sum_reg  <= '0;
      carry    <= 1'b0;
      cout_reg <= 1'b0;
      ovf_reg  <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= a;
            b_reg <= b_load;
            carry <= carry_load;
            cnt   <= '0;
          end
        end
        RUN: begin
          for (int k = 0; k < NIBBLES; k++) begin
            if (cnt == CW'(k)) sum_reg[4*k +: 4] <= s4;
          end
          carry <= c[4];
          if (last) begin
            cout_reg <= c[4];
            ovf_reg  <= c[3] ^ c[4];
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign sum       = sum_reg;
  assign cout      = cout_reg;
  assign ovf       = ovf_reg;

endmodule

// File: tb/tb_cla_nibble_serial_adder.sv
// Directed testbench for cla_nibble_serial_adder: a WIDTH=16 and a WIDTH=4
// instance driven with hand-computed vectors. Subtract vectors are exercised
// when CLA_SERIAL_SUB_EN is defined.
module tb_cla_nibble_serial_adder;

  logic clk;
  logic rst_n;

  logic        in_valid16, in_ready16, out_valid16, out_ready16;
  logic [15:0] a16, b16, sum16;
  logic        cin16, cout16, ovf16, busy16;

  logic        in_valid4, in_ready4, out_valid4, out_ready4;
  logic [3:0]  a4, b4, sum4;
  logic        cin4, cout4, ovf4, busy4;

`ifdef CLA_SERIAL_SUB_EN
  logic sub16;
  logic sub4;
`endif

  int checks;
  int failures;

  cla_nibble_serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .cin(cin16),
`ifdef CLA_SERIAL_SUB_EN
    .sub(sub16),
`endif
    .out_valid(out_valid16), .out_ready(out_ready16),
    .sum(sum16), .cout(cout16), .ovf(ovf16), .busy(busy16)
  );

  cla_nibble_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .cin(cin4),
`ifdef CLA_SERIAL_SUB_EN
    .sub(sub4),
`endif
    .out_valid(out_valid4), .out_ready(out_ready4),
    .sum(sum4), .cout(cout4), .ovf(ovf4), .busy(busy4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Present operands for one cycle to the 16-bit instance (must be in IDLE)
  task automatic start16(input logic [15:0] av, input logic [15:0] bv,
                         input logic cv, input logic sv);
    a16 = av;
    b16 = bv;
    cin16 = cv;
`ifdef CLA_SERIAL_SUB_EN
    sub16 = sv;
`else
    if (sv) $display("[TB] note: sub requested without CLA_SERIAL_SUB_EN");
`endif
    in_valid16 = 1'b1;
    @(posedge clk);
    #1;
    in_valid16 = 1'b0;
  endtask

  // Count clock edges until out_valid16 rises, bounded by limit
  task automatic wait_valid16(input int limit, output int cycles);
    cycles = 0;
    while (out_valid16 !== 1'b1 && cycles < limit) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic release16();
    out_ready16 = 1'b1;
    @(posedge clk);
    #1;
    out_ready16 = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (in_ready16 !== 1'b1 || out_valid16 !== 1'b0 || busy16 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_ctrl16: got ready=%b valid=%b busy=%b expected 1 0 0",
               in_ready16, out_valid16, busy16);
    end
    checks++;
    if (sum16 !== 16'h0000 || cout16 !== 1'b0 || ovf16 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_data16: got sum=%h cout=%b ovf=%b expected 0000 0 0",
               sum16, cout16, ovf16);
    end
    checks++;
    if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0 || busy4 !== 1'b0 ||
        sum4 !== 4'h0 || cout4 !== 1'b0 || ovf4 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_w4: got ready=%b valid=%b busy=%b sum=%h cout=%b ovf=%b expected 1 0 0 0 0 0",
               in_ready4, out_valid4, busy4, sum4, cout4, ovf4);
    end
  endtask

  task automatic test_basic_add();
    int cyc;
    checks++;
    if (in_ready16 !== 1'b1) begin
      failures++;
      $display("[TB] FAIL basic_ready: got %b expected 1", in_ready16);
    end
    start16(16'h1234, 16'h4321, 1'b0, 1'b0);
    checks++;
    if (busy16 !== 1'b1 || in_ready16 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_busy: got busy=%b ready=%b expected 1 0", busy16, in_ready16);
    end
    wait_valid16(20, cyc);
    checks++;
    if (cyc !== 4) begin
      failures++;
      $display("[TB] FAIL basic_latency: got %0d expected 4", cyc);
    end
    checks++;
    if (sum16 !== 16'h5555 || cout16 !== 1'b0 || ovf16 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_result: got sum=%h cout=%b ovf=%b expected 5555 0 0",
               sum16, cout16, ovf16);
    end
    release16();
    checks++;
    if (out_valid16 !== 1'b0 || in_ready16 !== 1'b1 || busy16 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_release: got valid=%b ready=%b busy=%b expected 0 1 0",
               out_valid16, in_ready16, busy16);
    end
  endtask

  task automatic test_carry_ripple();
    int cyc;
    start16(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    wait_valid16(20, cyc);
    checks++;
    if (cyc !== 4 || sum16 !== 16'h0000 || cout16 !== 1'b1 || ovf16 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ripple_ffff: got lat=%0d sum=%h cout=%b ovf=%b expected 4 0000 1 0",
               cyc, sum16, cout16, ovf16);
    end
    release16();
    start16(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    wait_valid16(20, cyc);
    checks++;
    if (cyc !== 4 || sum16 !== 16'h8000 || cout16 !== 1'b0 || ovf16 !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ripple_7fff: got lat=%0d sum=%h cout=%b ovf=%b expected 4 8000 0 1",
               cyc, sum16, cout16, ovf16);
    end
    release16();
    start16(16'h8000, 16'h8000, 1'b1, 1'b0);
    wait_valid16(20, cyc);
    checks++;
    if (sum16 !== 16'h0001 || cout16 !== 1'b1 || ovf16 !== 1'b1) begin
      failures++;
      $display("[TB] FAIL neg_ovf: got sum=%h cout=%b ovf=%b expected 0001 1 1",
               sum16, cout16, ovf16);
    end
    release16();
  endtask

  task automatic test_backpressure();
    int cyc;
    start16(16'h0F0F, 16'h0101, 1'b1, 1'b0);
    wait_valid16(20, cyc);
    checks++;
    if (cyc !== 4 || sum16 !== 16'h1011 || cout16 !== 1'b0 || ovf16 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bp_result: got lat=%0d sum=%h cout=%b ovf=%b expected 4 1011 0 0",
               cyc, sum16, cout16, ovf16);
    end
    a16 = 16'hFFFF;
    b16 = 16'hFFFF;
    cin16 = 1'b1;
    in_valid16 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (sum16 !== 16'h1011 || cout16 !== 1'b0 || ovf16 !== 1'b0 ||
          out_valid16 !== 1'b1 || in_ready16 !== 1'b0) begin
        failures++;
        $display("[TB] FAIL bp_hold%0d: got sum=%h cout=%b ovf=%b valid=%b ready=%b expected 1011 0 0 1 0",
                 i, sum16, cout16, ovf16, out_valid16, in_ready16);
      end
    end
    in_valid16 = 1'b0;
    release16();
    @(posedge clk);
    #1;
    checks++;
    if (busy16 !== 1'b0 || in_ready16 !== 1'b1 || sum16 !== 16'h1011) begin
      failures++;
      $display("[TB] FAIL bp_idle_keep: got busy=%b ready=%b sum=%h expected 0 1 1011",
               busy16, in_ready16, sum16);
    end
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    bit seen_valid;
    start16(16'hABCD, 16'h1111, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready16 !== 1'b1 || out_valid16 !== 1'b0 || busy16 !== 1'b0 ||
        sum16 !== 16'h0000 || cout16 !== 1'b0 || ovf16 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midrun_reset: got ready=%b valid=%b busy=%b sum=%h cout=%b ovf=%b expected 1 0 0 0000 0 0",
               in_ready16, out_valid16, busy16, sum16, cout16, ovf16);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (out_valid16 === 1'b1 || busy16 === 1'b1) seen_valid = 1'b1;
    end
    checks++;
    if (seen_valid) begin
      failures++;
      $display("[TB] FAIL midrun_no_valid: got activity=1 expected 0");
    end
    start16(16'h0001, 16'h0001, 1'b1, 1'b0);
    wait_valid16(20, cyc);
    checks++;
    if (cyc !== 4 || sum16 !== 16'h0003 || cout16 !== 1'b0 || ovf16 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midrun_after: got lat=%0d sum=%h cout=%b ovf=%b expected 4 0003 0 0",
               cyc, sum16, cout16, ovf16);
    end
    release16();
  endtask

  task automatic test_width4();
    int cyc;
    a4 = 4'h9;
    b4 = 4'h8;
    cin4 = 1'b1;
    in_valid4 = 1'b1;
    @(posedge clk);
    #1;
    in_valid4 = 1'b0;
    cyc = 0;
    while (out_valid4 !== 1'b1 && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checks++;
    if (cyc !== 1) begin
      failures++;
      $display("[TB] FAIL w4_latency: got %0d expected 1", cyc);
    end
    checks++;
    if (sum4 !== 4'h2 || cout4 !== 1'b1 || ovf4 !== 1'b1) begin
      failures++;
      $display("[TB] FAIL w4_result: got sum=%h cout=%b ovf=%b expected 2 1 1",
               sum4, cout4, ovf4);
    end
    out_ready4 = 1'b1;
    @(posedge clk);
    #1;
    out_ready4 = 1'b0;
    checks++;
    if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1) begin
      failures++;
      $display("[TB] FAIL w4_release: got valid=%b ready=%b expected 0 1", out_valid4, in_ready4);
    end
  endtask

`ifdef CLA_SERIAL_SUB_EN
  task automatic test_sub();
    int cyc;
    start16(16'h0005, 16'h0007, 1'b0, 1'b1);
    wait_valid16(20, cyc);
    checks++;
    if (cyc !== 4 || sum16 !== 16'hFFFE || cout16 !== 1'b0 || ovf16 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL sub_borrow: got lat=%0d sum=%h cout=%b ovf=%b expected 4 fffe 0 0",
               cyc, sum16, cout16, ovf16);
    end
    release16();
    start16(16'h0007, 16'h0005, 1'b0, 1'b1);
    wait_valid16(20, cyc);
    checks++;
    if (cyc !== 4 || sum16 !== 16'h0002 || cout16 !== 1'b1 || ovf16 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL sub_noborrow: got lat=%0d sum=%h cout=%b ovf=%b expected 4 0002 1 0",
               cyc, sum16, cout16, ovf16);
    end
    release16();
    sub16 = 1'b0;
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    in_valid16 = 1'b0; out_ready16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
    in_valid4 = 1'b0;  out_ready4 = 1'b0;  a4 = '0;  b4 = '0;  cin4 = 1'b0;
`ifdef CLA_SERIAL_SUB_EN
    sub16 = 1'b0;
    sub4 = 1'b0;
`endif
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_basic_add();
    test_carry_ripple();
    test_backpressure();
    test_reset_mid_run();
    test_width4();
`ifdef CLA_SERIAL_SUB_EN
    test_sub();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
